// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - RV32I-subset decode stage with register file, load-use stall and ID/EX register
module decode_stage_hz #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int WB_BYPASS    = 1,
    parameter int LOAD_USE_DET = 1,
    localparam int AW          = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic            valid_d,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            reg_write_w,
    input  logic [AW-1:0]   rd_w,
    input  logic [XLEN-1:0] result_w,
    output logic            valid_e,
    output logic            reg_write_e,
    output logic            alu_src_e,
    output logic            mem_write_e,
    output logic            branch_e,
    output logic            jump_e,
    output logic [1:0]      result_src_e,
    output logic [3:0]      alu_control_e,
    output logic [2:0]      funct3_e,
    output logic            illegal_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [AW-1:0]   rs1_e,
    output logic [AW-1:0]   rs2_e,
    output logic [AW-1:0]   rd_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic            stall_req_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    logic            dec_reg_write;
    logic            dec_alu_src;
    logic            dec_mem_write;
    logic            dec_branch;
    logic            dec_jump;
    logic [1:0]      dec_result_src;
    logic [3:0]      dec_alu;
    logic            dec_illegal;
    logic [31:0]     dec_imm;
    logic            uses_rs2;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign rs1    = instr_d[15 +: AW];
    assign rs2    = instr_d[20 +: AW];
    assign rd     = instr_d[7 +: AW];

    // funct7[5] selects SUB only for R-type; shifts right use it for both R and I forms
    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic f7b5, input logic is_r);
        case (f3)
            3'b000:  alu_arith = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_arith = ALU_SLL;
            3'b010:  alu_arith = ALU_SLT;
            3'b011:  alu_arith = ALU_SLTU;
            3'b100:  alu_arith = ALU_XOR;
            3'b101:  alu_arith = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_arith = ALU_OR;
            default: alu_arith = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_result_src = 2'b00;
        dec_alu        = ALU_ADD;
        dec_illegal    = 1'b0;
        dec_imm        = 32'd0;
        uses_rs2       = 1'b0;
        case (opcode)
            OP_R: begin
                dec_reg_write = 1'b1;
                uses_rs2      = 1'b1;
                dec_alu       = alu_arith(funct3, instr_d[30], 1'b1);
            end
            OP_I: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = {{20{instr_d[31]}}, instr_d[31:20]};
                dec_alu       = alu_arith(funct3, instr_d[30], 1'b0);
            end
            OP_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 2'b01;
                dec_imm        = {{20{instr_d[31]}}, instr_d[31:20]};
            end
            OP_STORE: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                uses_rs2      = 1'b1;
                dec_imm       = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            end
            OP_BR: begin
                dec_branch = 1'b1;
                uses_rs2   = 1'b1;
                dec_alu    = ALU_SUB;
                dec_imm    = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
            end
            OP_JAL: begin
                dec_reg_write  = 1'b1;
                dec_jump       = 1'b1;
                dec_result_src = 2'b10;
                dec_imm        = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
            end
            OP_LUI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu       = ALU_PASSB;
                dec_imm       = {instr_d[31:12], 12'd0};
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write_w && rd_w != '0) begin
            regs[rd_w] <= result_w;
        end
    end

    always_comb begin
        rd1 = regs[rs1];
        rd2 = regs[rs2];
        if (WB_BYPASS != 0 && reg_write_w && rd_w != '0) begin
            if (rd_w == rs1) rd1 = result_w;
            if (rd_w == rs2) rd2 = result_w;
        end
        if (rs1 == '0) rd1 = '0;
        if (rs2 == '0) rd2 = '0;
    end

    assign stall_req_o = (LOAD_USE_DET != 0) && valid_e && result_src_e == 2'b01 && rd_e != '0 &&
                         valid_d && (rd_e == rs1 || (rd_e == rs2 && uses_rs2));

    // Bubbles only clear control; data fields keep stale values since EX ignores them
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_e       <= 1'b0;
            reg_write_e   <= 1'b0;
            alu_src_e     <= 1'b0;
            mem_write_e   <= 1'b0;
            branch_e      <= 1'b0;
            jump_e        <= 1'b0;
            result_src_e  <= 2'b00;
            alu_control_e <= 4'd0;
            funct3_e      <= 3'd0;
            illegal_e     <= 1'b0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_ext_e     <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
        end else if (flush_i || (!stall_i && stall_req_o)) begin
            valid_e      <= 1'b0;
            reg_write_e  <= 1'b0;
            mem_write_e  <= 1'b0;
            branch_e     <= 1'b0;
            jump_e       <= 1'b0;
            illegal_e    <= 1'b0;
            result_src_e <= 2'b00;
        end else if (!stall_i) begin
            valid_e       <= valid_d;
            reg_write_e   <= valid_d && dec_reg_write;
            alu_src_e     <= dec_alu_src;
            mem_write_e   <= valid_d && dec_mem_write;
            branch_e      <= valid_d && dec_branch;
            jump_e        <= valid_d && dec_jump;
            result_src_e  <= valid_d ? dec_result_src : 2'b00;
            alu_control_e <= dec_alu;
            funct3_e      <= funct3;
            illegal_e     <= valid_d && dec_illegal;
            rd1_e         <= rd1;
            rd2_e         <= rd2;
            imm_ext_e     <= dec_imm;
            rs1_e         <= rs1;
            rs2_e         <= rs2;
            rd_e          <= rd;
            pc_e          <= pc_d;
            pc_plus4_e    <= pc_plus4_d;
        end
    end

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb/tb_decode_stage_hz.sv - scoreboard bench for decode_stage_hz
module tb_decode_stage_hz;

    typedef struct packed {
        logic        v, rw, as, mw, br, j;
        logic [1:0]  rs;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        ill;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pc4;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_d = 32'd0, pc_d = 32'd0, pc_plus4_d = 32'd4, result_w = 32'd0;
    logic        valid_d = 1'b0, stall_i = 1'b0, flush_i = 1'b0, reg_write_w = 1'b0;
    logic [4:0]  rd_w = 5'd0;

    logic        valid_e, reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e, illegal_e, stall_req_o;
    logic [1:0]  result_src_e;
    logic [3:0]  alu_control_e;
    logic [2:0]  funct3_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    logic        b_valid_e, b_reg_write_e, b_alu_src_e, b_mem_write_e, b_branch_e, b_jump_e, b_illegal_e, b_stall_req_o;
    logic [1:0]  b_result_src_e;
    logic [3:0]  b_alu_control_e;
    logic [2:0]  b_funct3_e;
    logic [31:0] b_rd1_e, b_rd2_e, b_imm_ext_e, b_pc_e, b_pc_plus4_e;
    logic [4:0]  b_rs1_e, b_rs2_e, b_rd_e;

    int   total = 0;
    int   bad = 0;
    ex_t  exp_q[$];
    ex_t  msk_q[$];
    ex_t  m_full, m_bub, m_noimm, m_dec, m_decr, m_ill, m_jal;
    ex_t  beq_exp;

    decode_stage_hz #(.WB_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .stall_i(stall_i), .flush_i(flush_i), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .alu_src_e(alu_src_e), .mem_write_e(mem_write_e),
        .branch_e(branch_e), .jump_e(jump_e), .result_src_e(result_src_e), .alu_control_e(alu_control_e),
        .funct3_e(funct3_e), .illegal_e(illegal_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .stall_req_o(stall_req_o)
    );

    decode_stage_hz #(.WB_BYPASS(0)) dut_nobyp (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .stall_i(stall_i), .flush_i(flush_i), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .valid_e(b_valid_e), .reg_write_e(b_reg_write_e), .alu_src_e(b_alu_src_e), .mem_write_e(b_mem_write_e),
        .branch_e(b_branch_e), .jump_e(b_jump_e), .result_src_e(b_result_src_e), .alu_control_e(b_alu_control_e),
        .funct3_e(b_funct3_e), .illegal_e(b_illegal_e), .rd1_e(b_rd1_e), .rd2_e(b_rd2_e), .imm_ext_e(b_imm_ext_e),
        .rs1_e(b_rs1_e), .rs2_e(b_rs2_e), .rd_e(b_rd_e), .pc_e(b_pc_e), .pc_plus4_e(b_pc_plus4_e),
        .stall_req_o(b_stall_req_o)
    );

    always #5 clk = ~clk;

    function automatic ex_t sample();
        ex_t s;
        s = {valid_e, reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e, result_src_e, alu_control_e,
             funct3_e, illegal_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e};
        return s;
    endfunction

    function automatic ex_t mk(input logic v, rw, as, mw, br, j, input logic [1:0] rs, input logic [3:0] alu,
                               input logic [2:0] f3, input logic ill, input logic [31:0] rd1, rd2, imm,
                               input logic [4:0] rs1, rs2, rd);
        ex_t e;
        e = {v, rw, as, mw, br, j, rs, alu, f3, ill, rd1, rd2, imm, rs1, rs2, rd, pc_d, pc_d + 32'd4};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] ins, input logic v);
        instr_d    = ins;
        valid_d    = v;
        pc_d       = pc_d + 32'd4;
        pc_plus4_d = pc_d + 32'd4;
    endtask

    task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        reg_write_w = we;
        rd_w        = r;
        result_w    = d;
    endtask

    task automatic issue(input ex_t e, input ex_t m);
        exp_q.push_back(e);
        msk_q.push_back(m);
        step();
    endtask

    task automatic test_reset();
        ex_t e, m;
        rst = 1'b1;
        issue('0, m_full);
        rst = 1'b0;
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL reset got=%h exp=%h", sample() & m, e & m); end
        total++;
        if (stall_req_o !== 1'b0) begin bad++; $display("FAIL reset_stall_req got=%b exp=0", stall_req_o); end
    endtask

    task automatic test_addi();
        ex_t e, m;
        drv(32'h00500093, 1'b1);
        wb(1'b1, 5'd1, 32'd5);
        issue(mk(1,1,1,0,0,0,2'b00,4'd0,3'd0,0,32'd0,32'd0,32'd5,5'd0,5'd5,5'd1), m_full);
        wb(1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL addi got=%h exp=%h", sample() & m, e & m); end
    endtask

    task automatic test_load_use();
        ex_t e, m;
        drv(32'h0000A103, 1'b1);
        issue(mk(1,1,1,0,0,0,2'b01,4'd0,3'd2,0,32'd5,32'd0,32'd0,5'd1,5'd0,5'd2), m_full);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL lw got=%h exp=%h", sample() & m, e & m); end
        drv(32'h002101B3, 1'b1);
        #1;
        total++;
        if (stall_req_o !== 1'b1) begin bad++; $display("FAIL load_use_req got=%b exp=1", stall_req_o); end
        wb(1'b1, 5'd2, 32'h22);
        issue('0, m_bub);
        wb(1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL load_use_bubble got=%h exp=%h", sample() & m, e & m); end
        total++;
        if (stall_req_o !== 1'b0) begin bad++; $display("FAIL load_use_release got=%b exp=0", stall_req_o); end
        issue(mk(1,1,0,0,0,0,2'b00,4'd0,3'd0,0,32'h22,32'h22,32'd0,5'd2,5'd2,5'd3), m_noimm);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL load_use_add got=%h exp=%h", sample() & m, e & m); end
        // rs2 field of an I-type matching the load rd must not stall
        drv(32'h0000A103, 1'b1);
        issue(mk(1,1,1,0,0,0,2'b01,4'd0,3'd2,0,32'd5,32'd0,32'd0,5'd1,5'd0,5'd2), m_full);
        e = exp_q.pop_front(); m = msk_q.pop_front();
        drv(32'h00200213, 1'b1);
        #1;
        total++;
        if (stall_req_o !== 1'b0) begin bad++; $display("FAIL itype_no_stall got=%b exp=0", stall_req_o); end
        issue(mk(1,1,1,0,0,0,2'b00,4'd0,3'd0,0,32'd0,32'h22,32'd2,5'd0,5'd2,5'd4), m_full);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL itype_issue got=%h exp=%h", sample() & m, e & m); end
    endtask

    task automatic test_bypass();
        ex_t e, m;
        drv(32'h00000013, 1'b0);
        wb(1'b1, 5'd5, 32'h11111111);
        step();
        drv(32'h00028333, 1'b1);
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        issue(mk(1,1,0,0,0,0,2'b00,4'd0,3'd0,0,32'hDEADBEEF,32'd0,32'd0,5'd5,5'd0,5'd6), m_noimm);
        wb(1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL bypass got=%h exp=%h", sample() & m, e & m); end
        total++;
        if (b_rd1_e !== 32'h11111111) begin bad++; $display("FAIL no_bypass_rd1 got=%h exp=11111111", b_rd1_e); end
    endtask

    task automatic test_flush();
        ex_t e, m;
        drv(32'h00208463, 1'b1);
        flush_i = 1'b1;
        issue('0, m_bub);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL flush got=%h exp=%h", sample() & m, e & m); end
        stall_i = 1'b1;
        issue('0, m_bub);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL flush_stall got=%h exp=%h", sample() & m, e & m); end
        flush_i = 1'b0;
        stall_i = 1'b0;
        beq_exp = mk(1,0,0,0,1,0,2'b00,4'd1,3'd0,0,32'd5,32'h22,32'd8,5'd1,5'd2,5'd8);
        issue(beq_exp, m_full);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL beq got=%h exp=%h", sample() & m, e & m); end
    endtask

    task automatic test_stall();
        ex_t e, m;
        stall_i = 1'b1;
        drv(32'h000003B3, 1'b1);
        wb(1'b1, 5'd0, 32'h0000FFFF);
        for (int i = 0; i < 3; i++) begin
            issue(beq_exp, m_full);
            e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
            if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, sample() & m, e & m); end
        end
        stall_i = 1'b0;
        issue(mk(1,1,0,0,0,0,2'b00,4'd0,3'd0,0,32'd0,32'd0,32'd0,5'd0,5'd0,5'd7), m_noimm);
        wb(1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL x0_read got=%h exp=%h", sample() & m, e & m); end
    endtask

    task automatic test_decode();
        ex_t e, m;
        logic [31:0] ins [11];
        logic        vld [11];
        ex_t         te  [11];
        ex_t         tm  [11];
        ins[0]  = 32'h0000007F; vld[0]  = 1; te[0]  = mk(1,0,0,0,0,0,2'b00,4'd0,3'd0,1,0,0,0,0,0,0);          tm[0]  = m_ill;
        ins[1]  = 32'h403100B3; vld[1]  = 1; te[1]  = mk(1,1,0,0,0,0,2'b00,4'd1,3'd0,0,0,0,0,0,0,0);          tm[1]  = m_decr;
        ins[2]  = 32'h403150B3; vld[2]  = 1; te[2]  = mk(1,1,0,0,0,0,2'b00,4'd8,3'd5,0,0,0,0,0,0,0);          tm[2]  = m_decr;
        ins[3]  = 32'h40315093; vld[3]  = 1; te[3]  = mk(1,1,1,0,0,0,2'b00,4'd8,3'd5,0,0,0,32'h403,0,0,0);    tm[3]  = m_dec;
        ins[4]  = 32'h12345237; vld[4]  = 1; te[4]  = mk(1,1,1,0,0,0,2'b00,4'd10,3'd5,0,0,0,32'h12345000,0,0,0); tm[4] = m_dec;
        ins[5]  = 32'h010000EF; vld[5]  = 1; te[5]  = mk(1,1,0,0,0,1,2'b10,4'd0,3'd0,0,0,0,32'd16,0,0,0);     tm[5]  = m_jal;
        ins[6]  = 32'h0020A223; vld[6]  = 1; te[6]  = mk(1,0,1,1,0,0,2'b00,4'd0,3'd2,0,0,0,32'd4,0,0,0);      tm[6]  = m_dec;
        ins[7]  = 32'hFFF00093; vld[7]  = 1; te[7]  = mk(1,1,1,0,0,0,2'b00,4'd0,3'd0,0,0,0,32'hFFFFFFFF,0,0,0); tm[7] = m_dec;
        ins[8]  = 32'h00717093; vld[8]  = 1; te[8]  = mk(1,1,1,0,0,0,2'b00,4'd2,3'd7,0,0,0,32'd7,0,0,0);      tm[8]  = m_dec;
        ins[9]  = 32'h003130B3; vld[9]  = 1; te[9]  = mk(1,1,0,0,0,0,2'b00,4'd9,3'd3,0,0,0,0,0,0,0);          tm[9]  = m_decr;
        ins[10] = 32'h00500093; vld[10] = 0; te[10] = '0;                                                     tm[10] = m_bub;
        for (int i = 0; i < 11; i++) begin
            drv(ins[i], vld[i]);
            issue(te[i], tm[i]);
            e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
            if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL decode%0d got=%h exp=%h", i, sample() & m, e & m); end
        end
    endtask

    task automatic test_reset_mid_stall();
        ex_t e, m;
        drv(32'h0000A103, 1'b1);
        issue(mk(1,1,1,0,0,0,2'b01,4'd0,3'd2,0,0,0,0,0,0,0), m_dec);
        e = exp_q.pop_front(); m = msk_q.pop_front();
        drv(32'h002101B3, 1'b1);
        rst = 1'b1;
        stall_i = 1'b1;
        issue('0, m_full);
        rst = 1'b0;
        stall_i = 1'b0;
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL reset_mid_stall got=%h exp=%h", sample() & m, e & m); end
        total++;
        if (stall_req_o !== 1'b0) begin bad++; $display("FAIL reset_stall_req2 got=%b exp=0", stall_req_o); end
        issue(mk(1,1,0,0,0,0,2'b00,4'd0,3'd0,0,32'd0,32'd0,32'd0,5'd2,5'd2,5'd3), m_noimm);
        e = exp_q.pop_front(); m = msk_q.pop_front(); total++;
        if ((sample() & m) !== (e & m)) begin bad++; $display("FAIL regfile_cleared got=%h exp=%h", sample() & m, e & m); end
    endtask

    initial begin
        m_full  = '1;
        m_bub   = '0;
        m_bub.v = 1'b1; m_bub.rw = 1'b1; m_bub.mw = 1'b1; m_bub.br = 1'b1; m_bub.j = 1'b1;
        m_noimm = m_full;
        m_noimm.imm = '0;
        m_dec   = m_bub;
        m_dec.as = 1'b1; m_dec.rs = '1; m_dec.alu = '1; m_dec.f3 = '1; m_dec.ill = 1'b1; m_dec.imm = '1;
        m_decr  = m_dec;
        m_decr.imm = '0;
        m_jal   = m_dec;
        m_jal.as = 1'b0; m_jal.alu = '0;
        m_ill   = m_bub;
        m_ill.ill = 1'b1;

        test_reset();
        test_addi();
        test_load_use();
        test_bypass();
        test_flush();
        test_stall();
        test_decode();
        test_reset_mid_stall();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
